// File: rtl/ldtu_bsl_estimator.sv
// Baseline estimator: averages 2^LOG2_NS raw samples of one gain channel into an 8-bit baseline.
// Optional build macro LDTU_BSL_MARGIN_EN subtracts MARGIN counts from the mean before saturation.
module ldtu_bsl_estimator #(
  parameter int unsigned Nbits_12 = 12,
  parameter int unsigned Nbits_8  = 8,
  parameter int unsigned LOG2_NS  = 4,
  parameter int unsigned MARGIN   = 3
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                START,
  input  logic                DATA_VALID,
  input  logic [Nbits_12-1:0] DATA12,
  output logic [Nbits_8-1:0]  BSL_VAL,
  output logic                BSL_VALID,
  output logic                BUSY,
  output logic                DONE,
  output logic                BSL_SAT
);

  localparam int unsigned AccW = Nbits_12 + LOG2_NS;

  if (LOG2_NS < 1 || LOG2_NS > 8 || MARGIN > 255) begin : g_param_check
    $error("ldtu_bsl_estimator: LOG2_NS must be 1..8 and MARGIN 0..255");
  end

  typedef enum logic [1:0] {StIdle, StAcc, StCalc, StDone} state_e;

  state_e              state_q, state_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [LOG2_NS-1:0]  cnt_q, cnt_d;
  logic [Nbits_12-1:0] mean_q, mean_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [Nbits_8-1:0]  val_q, val_d;
  logic                valid_q, valid_d;
  logic                sat_q, sat_d;

  logic [Nbits_12-1:0] mean_adj;
  logic                mean_sat;

`ifdef LDTU_BSL_MARGIN_EN
  localparam logic [Nbits_12-1:0] MarginW = Nbits_12'(MARGIN);
  assign mean_adj = (mean_q >= MarginW) ? (mean_q - MarginW) : '0;
`else
  assign mean_adj = mean_q;
`endif

  assign mean_sat = |mean_adj[Nbits_12-1:Nbits_8];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mean_d  = mean_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    val_d   = val_q;
    valid_d = valid_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        // A START coinciding with the DONE pulse is dropped, not queued.
        if (START && !done_q) begin
          state_d = StAcc;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StAcc: begin
        if (DATA_VALID) begin
          acc_d = acc_q + AccW'(DATA12);
          cnt_d = cnt_q + LOG2_NS'(1);
          if (cnt_q == {LOG2_NS{1'b1}}) begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        mean_d  = Nbits_12'(acc_q >> LOG2_NS);
        // BUSY covers START plus the accumulate/divide window only.
        busy_d  = 1'b0;
        state_d = StDone;
      end
      StDone: begin
        val_d   = mean_sat ? {Nbits_8{1'b1}} : mean_adj[Nbits_8-1:0];
        sat_d   = mean_sat;
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      mean_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      val_q   <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mean_q  <= mean_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      val_q   <= val_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign BSL_VAL   = val_q;
  assign BSL_VALID = valid_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign BSL_SAT   = sat_q;

endmodule

// File: tb/tb_ldtu_bsl_estimator.sv
// Self-checking bench for ldtu_bsl_estimator: directed and random calibrations against a mean model.
module tb_ldtu_bsl_estimator;

  localparam int unsigned LOG2_NS = 4;
  localparam int unsigned NS      = 1 << LOG2_NS;
  localparam int unsigned MARGIN  = 3;

  logic        CLK = 1'b0;
  logic        rst;
  logic        START;
  logic        DATA_VALID;
  logic [11:0] DATA12;
  logic [7:0]  BSL_VAL;
  logic        BSL_VALID;
  logic        BUSY;
  logic        DONE;
  logic        BSL_SAT;

  int n_assert = 0;
  int n_fail   = 0;
  logic [11:0] samp [NS];

  ldtu_bsl_estimator #(
    .Nbits_12 (12),
    .Nbits_8  (8),
    .LOG2_NS  (LOG2_NS),
    .MARGIN   (MARGIN)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .START      (START),
    .DATA_VALID (DATA_VALID),
    .DATA12     (DATA12),
    .BSL_VAL    (BSL_VAL),
    .BSL_VALID  (BSL_VALID),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .BSL_SAT    (BSL_SAT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected {sat, value}: plain average of the sample set, optional margin, clip to 8 bits.
  function automatic logic [8:0] model();
    int unsigned sum;
    int unsigned mean;
    sum = 0;
    for (int i = 0; i < NS; i++) sum += samp[i];
    mean = sum / NS;
`ifdef LDTU_BSL_MARGIN_EN
    mean = (mean >= MARGIN) ? mean - MARGIN : 0;
`endif
    if (mean > 255) return {1'b1, 8'hFF};
    return {1'b0, 8'(mean)};
  endfunction

  task automatic fill_const(input logic [11:0] v);
    for (int i = 0; i < NS; i++) samp[i] = v;
  endtask

  task automatic fill_rand(input int unsigned hi);
    for (int i = 0; i < NS; i++) samp[i] = 12'($urandom_range(hi, 0));
  endtask

  // One full calibration; gaps inserts an idle cycle after every valid sample,
  // poke re-issues START mid-run and while DONE is visible.
  task automatic calibrate(input string tag, input bit gaps, input bit poke);
    int c, k, done_c, last_c, dones, busy_cnt;
    logic [7:0] old_val;
    logic       old_valid;
    bit         held;
    logic [8:0] e;
    e         = model();
    old_val   = BSL_VAL;
    old_valid = BSL_VALID;
    held      = 1'b1;
    START      = 1'b1;
    DATA_VALID = 1'b0;
    step();
    START    = 1'b0;
    c        = 0;
    k        = 0;
    done_c   = -1;
    last_c   = -1;
    dones    = 0;
    busy_cnt = BUSY ? 1 : 0;
    while (c < 150 && (done_c < 0 || c < done_c + 3)) begin
      START = poke && (c == 2 || c == 9 || c == done_c);
      if (k < NS && (!gaps || (c % 2) == 0)) begin
        DATA_VALID = 1'b1;
        DATA12     = samp[k];
        k++;
      end else begin
        DATA_VALID = 1'b0;
        DATA12     = 12'($urandom);
      end
      step();
      c++;
      if (k == NS && last_c < 0) last_c = c;
      if (BUSY) busy_cnt++;
      if (DONE) begin
        dones++;
        if (done_c < 0) done_c = c;
      end else if (done_c < 0 && (BSL_VAL !== old_val || BSL_VALID !== old_valid)) begin
        held = 1'b0;
      end
    end
    START      = 1'b0;
    DATA_VALID = 1'b0;
    check($sformatf("%s.done_count", tag), dones, 1);
    check($sformatf("%s.done_latency", tag), done_c, last_c + 2);
    check($sformatf("%s.busy_cycles", tag), busy_cnt, last_c + 1);
    check($sformatf("%s.held_until_done", tag), {31'd0, held}, 1);
    check($sformatf("%s.bsl_val", tag), {24'd0, BSL_VAL}, {24'd0, e[7:0]});
    check($sformatf("%s.bsl_sat", tag), {31'd0, BSL_SAT}, {31'd0, e[8]});
    check($sformatf("%s.bsl_valid", tag), {31'd0, BSL_VALID}, 1);
    check($sformatf("%s.busy_end", tag), {31'd0, BUSY}, 0);
  endtask

  initial begin
    rst        = 1'b1;
    START      = 1'b0;
    DATA_VALID = 1'b0;
    DATA12     = '0;
    step();
    step();
    check("reset.bsl_val", {24'd0, BSL_VAL}, 0);
    check("reset.bsl_valid", {31'd0, BSL_VALID}, 0);
    check("reset.busy", {31'd0, BUSY}, 0);
    check("reset.done", {31'd0, DONE}, 0);
    check("reset.bsl_sat", {31'd0, BSL_SAT}, 0);
    rst = 1'b0;
    step();

    // Prime with a real estimate so the async reset below has something to clear.
    fill_rand(4095);
    calibrate("rand_first", 1'b0, 1'b0);

    // Abort after 5 samples with an asynchronous reset.
    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      DATA_VALID = 1'b1;
      DATA12     = 12'd700;
      step();
    end
    DATA_VALID = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t1_abort.bsl_val", {24'd0, BSL_VAL}, 0);
    check("t1_abort.bsl_valid", {31'd0, BSL_VALID}, 0);
    check("t1_abort.busy", {31'd0, BUSY}, 0);
    check("t1_abort.done", {31'd0, DONE}, 0);
    check("t1_abort.bsl_sat", {31'd0, BSL_SAT}, 0);
    step();
    rst = 1'b0;
    step();
    fill_const(12'd100);
    calibrate("t1_after", 1'b0, 1'b0);

    for (int i = 0; i < NS; i++) samp[i] = (i % 2 == 0) ? 12'd90 : 12'd110;
    calibrate("t2_alt", 1'b0, 1'b0);

    fill_const(12'd1000);
    calibrate("t3_sat", 1'b0, 1'b0);
    fill_const(12'hFFF);
    calibrate("t3_full", 1'b0, 1'b0);

    fill_const(12'd50);
    calibrate("t4_gaps", 1'b1, 1'b0);

    fill_rand(300);
    calibrate("t5_poke", 1'b1, 1'b1);
    fill_rand(200);
    calibrate("t5_hold", 1'b0, 1'b1);

    fill_const(12'd40);
    calibrate("t6_forty", 1'b0, 1'b0);
    fill_const(12'd2);
    calibrate("t6_two", 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill_rand((r % 2 == 0) ? 4095 : 400);
      calibrate($sformatf("rand%0d", r), r[0], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
